dep_rule_cfg_seq: RTL and testbench

Sequencer in front of the deparser rule-configuration write port (32b wren/addr/wdata). It accepts whole-rule load/delete descriptors from two requesters (0 = host CPU path, 1 = local table manager) and arbitrates between them round-robin. It expands each granted descriptor into the ordered single-word write burst the rule-config block expects. The rule-commit write is always last, so a rule never becomes valid with partially written fields.

---
 rtl/dep_cfg_pkg.sv | 66 ++++++
 rtl/dep_rr_arb2.sv | 56 +++++
 rtl/dep_rule_cfg_seq.sv | 211 +++++++++++++++++++++
 tb/tb_dep_rule_cfg_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dep_cfg_pkg.sv
// Shared definitions for the deparser rule-configuration sequencer.
// Holds the rule geometry constants, the whole-rule descriptor, the
// config-op encoding used in write addresses (bits [10:8]), the sequencer
// state encoding and a helper that forms a config write address.
package dep_cfg_pkg;

  localparam int TYPE_NUM          = 4;
  localparam int TYPE_WIDTH        = 16;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_FIELD_NUM     = 8;
  localparam int KEY_OFFSET_WIDTH  = 5;
  localparam int HEAD_SHIFT_WIDTH  = 6;
  localparam int META_SHIFT_WIDTH  = 4;
  localparam int RULE_ID_WIDTH     = 6;

  // One counter serves every burst state, so it is sized for the longest one.
  localparam int CNT_MAX    = (TYPE_NUM > KEY_FIELD_NUM) ? TYPE_NUM : KEY_FIELD_NUM;
  localparam int CNT_WIDTH  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TIDX_WIDTH = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
  localparam int KIDX_WIDTH = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

  typedef struct packed {
    logic                                               del;
    logic [RULE_ID_WIDTH-1:0]                           rule_id;
    logic                                               rule_valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_data;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_mask;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]         type_offset;
    logic [KEY_FIELD_NUM-1:0]                           key_valid;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]     key_offset;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]     key_replace;
    logic [HEAD_SHIFT_WIDTH-1:0]                        head_shift;
    logic [META_SHIFT_WIDTH-1:0]                        meta_shift;
  } rule_desc_t;

  typedef enum logic [2:0] {
    OP_RULE = 3'd0,
    OP_TYPE = 3'd1,
    OP_TOFF = 3'd2,
    OP_KEY  = 3'd3,
    OP_HEAD = 3'd4,
    OP_META = 3'd5
  } cfg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TYPE   = 3'd1,
    ST_TOFF   = 3'd2,
    ST_KEY    = 3'd3,
    ST_HEAD   = 3'd4,
    ST_META   = 3'd5,
    ST_COMMIT = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_e;

  // Config address: op in [10:8], entry/rule index in the low bits, rest zero.
  function automatic logic [31:0] cfg_addr(input cfg_op_e op,
                                           input logic [RULE_ID_WIDTH-1:0] idx);
    logic [31:0] a;
    a = 32'd0;
    a[10:8] = op;
    a[RULE_ID_WIDTH-1:0] = idx;
    return a;
  endfunction

endpackage

// File: rtl/dep_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   i_valid[1:0]   : requests
//   i_accept       : the current grant is being taken this cycle
//   o_grant[1:0]   : one-hot grant (zero when no request)
//   o_grant_idx    : index of the granted requester
// With both requesting, the pointer side wins; the pointer then moves to the
// side that was not granted, so a continuously requesting pair alternates.
module dep_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic ptr_q;
  logic ptr_d;
  logic idx_s;

  // Grant selection and pointer next-state.
  always_comb begin
    idx_s   = 1'b0;
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   idx_s = 1'b0;
      2'b10:   idx_s = 1'b1;
      2'b11:   idx_s = ptr_q;
      default: idx_s = 1'b0;
    endcase
    if (i_valid != 2'b00) begin
      o_grant = idx_s ? 2'b10 : 2'b01;
    end else begin
      o_grant = 2'b00;
    end
    if (i_accept) begin
      ptr_d = ~idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign o_grant_idx = idx_s;

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dep_rule_cfg_seq.sv
// Rule-configuration write sequencer.
// Accepts whole-rule load/delete descriptors from two requesters (round-robin)
// and expands each into the ordered single-word write burst of the rule-config
// block: TYPE x TYPE_NUM, TOFF x TYPE_NUM, KEY x KEY_FIELD_NUM, HEAD, META,
// then COMMIT last so a rule only turns valid once all its fields are written.
// A delete issues only the COMMIT write (valid bit cleared).
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  : per-requester descriptor handshake (IDLE only)
//   i_req_desc               : per-requester rule descriptor
//   o_req_done               : one-cycle pulse to the requester whose burst ended
//   o_busy                   : high from the cycle after accept through done
//   o_rule_wren/addr/wdata   : registered write port, addr/wdata zero when idle
module dep_rule_cfg_seq
  import dep_cfg_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  rule_desc_t [1:0]    i_req_desc,
  output logic [1:0]          o_req_done,
  output logic                o_busy,
  output logic                o_rule_wren,
  output logic [31:0]         o_rule_addr,
  output logic [31:0]         o_rule_wdata
);

  localparam logic [CNT_WIDTH-1:0] TYPE_LAST = CNT_WIDTH'(TYPE_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] KEY_LAST  = CNT_WIDTH'(KEY_FIELD_NUM - 1);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  rule_desc_t           desc_q, desc_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 wren_q, wren_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           done_q, done_d;
  logic                 busy_q, busy_d;

  logic [1:0]           grant_s;
  logic                 grant_idx_s;
  logic                 accept_s;
  logic [63:0]          word_s;

  // Builds {addr, wdata} for one burst word; unlisted bits stay zero.
  function automatic logic [63:0] build_word(input seq_state_e st,
                                             input logic [CNT_WIDTH-1:0] c,
                                             input rule_desc_t d);
    logic [31:0]           a;
    logic [31:0]           w;
    logic [TIDX_WIDTH-1:0] ti;
    logic [KIDX_WIDTH-1:0] ki;
    a  = 32'd0;
    w  = 32'd0;
    ti = c[TIDX_WIDTH-1:0];
    ki = c[KIDX_WIDTH-1:0];
    case (st)
      ST_TYPE: begin
        a = cfg_addr(OP_TYPE, RULE_ID_WIDTH'(c));
        w[16 +: TYPE_WIDTH] = d.type_data[ti];
        w[0 +: TYPE_WIDTH]  = d.type_mask[ti];
      end
      ST_TOFF: begin
        a = cfg_addr(OP_TOFF, RULE_ID_WIDTH'(c));
        w[0 +: TYPE_OFFSET_WIDTH] = d.type_offset[ti];
      end
      ST_KEY: begin
        a = cfg_addr(OP_KEY, RULE_ID_WIDTH'(c));
        w[16] = d.key_valid[ki];
        w[8 +: KEY_OFFSET_WIDTH] = d.key_replace[ki];
        w[0 +: KEY_OFFSET_WIDTH] = d.key_offset[ki];
      end
      ST_HEAD: begin
        a = cfg_addr(OP_HEAD, {RULE_ID_WIDTH{1'b0}});
        w[0 +: HEAD_SHIFT_WIDTH] = d.head_shift;
      end
      ST_META: begin
        a = cfg_addr(OP_META, {RULE_ID_WIDTH{1'b0}});
        w[0 +: META_SHIFT_WIDTH] = d.meta_shift;
      end
      ST_COMMIT: begin
        a = cfg_addr(OP_RULE, d.rule_id);
        w[0] = d.del ? 1'b0 : d.rule_valid;
      end
      default: begin
        a = 32'd0;
        w = 32'd0;
      end
    endcase
    return {a, w};
  endfunction

  dep_rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_req_valid),
    .i_accept    (accept_s),
    .o_grant     (grant_s),
    .o_grant_idx (grant_idx_s)
  );

  // Ready is only offered in IDLE; gating with reset keeps it low while held in reset.
  always_comb begin
    if ((state_q == ST_IDLE) && i_rst_n) begin
      o_req_ready = grant_s;
    end else begin
      o_req_ready = 2'b00;
    end
    accept_s = |(i_req_valid & o_req_ready);
  end

  // Next state plus the output word that goes with the next state, so the
  // registered write port shows the word of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    gnt_d   = gnt_q;
    wren_d  = 1'b0;
    addr_d  = 32'd0;
    wdata_d = 32'd0;
    done_d  = 2'b00;
    word_s  = 64'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          desc_d  = i_req_desc[grant_idx_s];
          gnt_d   = grant_s;
          cnt_d   = {CNT_WIDTH{1'b0}};
          state_d = i_req_desc[grant_idx_s].del ? ST_COMMIT : ST_TYPE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TYPE: begin
        if (cnt_q == TYPE_LAST) begin
          state_d = ST_TOFF;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_TOFF: begin
        if (cnt_q == TYPE_LAST) begin
          state_d = ST_KEY;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_KEY: begin
        if (cnt_q == KEY_LAST) begin
          state_d = ST_HEAD;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_HEAD:   state_d = ST_META;
      ST_META:   state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if ((state_d != ST_IDLE) && (state_d != ST_DONE)) begin
      word_s  = build_word(state_d, cnt_d, desc_d);
      wren_d  = 1'b1;
      addr_d  = word_s[63:32];
      wdata_d = word_s[31:0];
    end else if (state_d == ST_DONE) begin
      done_d = gnt_q;
    end else begin
      done_d = 2'b00;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, descriptor and registered output port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_WIDTH{1'b0}};
      desc_q  <= '0;
      gnt_q   <= 2'b00;
      wren_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      gnt_q   <= gnt_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rule_wren  = wren_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_req_done   = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_dep_rule_cfg_seq.sv
// Directed bench for dep_rule_cfg_seq: reset values, one full load burst
// against a hand-computed word table, a delete, back-to-back arbitration,
// reset in the middle of a burst, and a requester dropping valid unserved.
module tb_dep_rule_cfg_seq;
  import dep_cfg_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  rule_desc_t [1:0]  req_desc;
  logic [1:0]        dut_ready;
  logic [1:0]        dut_done;
  logic              dut_busy;
  logic              dut_wren;
  logic [31:0]       dut_addr;
  logic [31:0]       dut_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  rule_desc_t load_d;
  rule_desc_t del_d;

  logic [31:0] exp_addr [0:18] = '{
    32'h100, 32'h101, 32'h102, 32'h103,
    32'h200, 32'h201, 32'h202, 32'h203,
    32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307,
    32'h400, 32'h500, 32'h005};
  logic [31:0] exp_wdata [0:18] = '{
    32'hAAAA00FF, 32'h1234F0F0, 32'h0800FFFF, 32'h86DD0F0F,
    32'h0000000C, 32'h00000017, 32'h00000020, 32'h000000FF,
    32'h00010001, 32'h00000102, 32'h00000203, 32'h00010907,
    32'h00000405, 32'h00011E1F, 32'h00001F00, 32'h00010810,
    32'h00000014, 32'h00000003, 32'h00000001};

  dep_rule_cfg_seq dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (dut_ready),
    .i_req_desc   (req_desc),
    .o_req_done   (dut_done),
    .o_busy       (dut_busy),
    .o_rule_wren  (dut_wren),
    .o_rule_addr  (dut_addr),
    .o_rule_wdata (dut_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds valid on requester r until it is accepted (or the budget runs out).
  task automatic issue(input int r, input rule_desc_t d, input int budget, output bit ok);
    req_desc[r]  = d;
    req_valid[r] = 1'b1;
    ok = 1'b0;
    #1;
    for (int i = 0; i < budget; i++) begin
      if (dut_ready[r]) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic build_descs();
    load_d = '0;
    load_d.rule_id    = 6'd5;
    load_d.rule_valid = 1'b1;
    load_d.type_data[0] = 16'hAAAA; load_d.type_mask[0] = 16'h00FF;
    load_d.type_data[1] = 16'h1234; load_d.type_mask[1] = 16'hF0F0;
    load_d.type_data[2] = 16'h0800; load_d.type_mask[2] = 16'hFFFF;
    load_d.type_data[3] = 16'h86DD; load_d.type_mask[3] = 16'h0F0F;
    load_d.type_offset[0] = 8'h0C; load_d.type_offset[1] = 8'h17;
    load_d.type_offset[2] = 8'h20; load_d.type_offset[3] = 8'hFF;
    load_d.key_valid = 8'b1010_1001;
    load_d.key_offset[0] = 5'd1;  load_d.key_replace[0] = 5'd0;
    load_d.key_offset[1] = 5'd2;  load_d.key_replace[1] = 5'd1;
    load_d.key_offset[2] = 5'd3;  load_d.key_replace[2] = 5'd2;
    load_d.key_offset[3] = 5'd7;  load_d.key_replace[3] = 5'd9;
    load_d.key_offset[4] = 5'd5;  load_d.key_replace[4] = 5'd4;
    load_d.key_offset[5] = 5'd31; load_d.key_replace[5] = 5'd30;
    load_d.key_offset[6] = 5'd0;  load_d.key_replace[6] = 5'd31;
    load_d.key_offset[7] = 5'd16; load_d.key_replace[7] = 5'd8;
    load_d.head_shift = 6'd20;
    load_d.meta_shift = 4'd3;
    del_d = '0;
    del_d.del        = 1'b1;
    del_d.rule_id    = 6'd12;
    del_d.rule_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (dut_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", dut_ready); end
    n_cmp++; if (dut_done !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", dut_done); end
    n_cmp++; if (dut_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", dut_busy); end
    n_cmp++; if (dut_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b want 0", dut_wren); end
    n_cmp++; if (dut_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", dut_addr); end
    n_cmp++; if (dut_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", dut_wdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    bit ok;
    issue(0, load_d, 5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL load_accept got %b want 1", ok); end
    for (int i = 0; i < 19; i++) begin
      n_cmp++;
      if ({dut_wren, dut_addr, dut_wdata} !== {1'b1, exp_addr[i], exp_wdata[i]}) begin
        n_bad++;
        $display("FAIL load_word%0d got wren=%b addr=%h wdata=%h want wren=1 addr=%h wdata=%h",
                 i, dut_wren, dut_addr, dut_wdata, exp_addr[i], exp_wdata[i]);
      end
      n_cmp++; if (dut_busy !== 1'b1) begin n_bad++; $display("FAIL load_busy%0d got %b want 1", i, dut_busy); end
      tick();
    end
    n_cmp++;
    if ({dut_wren, dut_addr, dut_wdata, dut_done, dut_busy} !== {1'b0, 32'd0, 32'd0, 2'b01, 1'b1}) begin
      n_bad++;
      $display("FAIL load_done got wren=%b addr=%h wdata=%h done=%b busy=%b want 0/0/0/01/1",
               dut_wren, dut_addr, dut_wdata, dut_done, dut_busy);
    end
    tick();
    n_cmp++; if ({dut_done, dut_busy} !== 3'b000) begin n_bad++; $display("FAIL load_idle got done=%b busy=%b want 00/0", dut_done, dut_busy); end
  endtask

  task automatic test_delete();
    bit ok;
    issue(1, del_d, 5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL del_accept got %b want 1", ok); end
    n_cmp++;
    if ({dut_wren, dut_addr, dut_wdata, dut_busy} !== {1'b1, 32'h0000000C, 32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL del_write got wren=%b addr=%h wdata=%h busy=%b want 1/0000000c/0/1",
               dut_wren, dut_addr, dut_wdata, dut_busy);
    end
    tick();
    n_cmp++;
    if ({dut_wren, dut_done, dut_busy} !== {1'b0, 2'b10, 1'b1}) begin
      n_bad++;
      $display("FAIL del_done got wren=%b done=%b busy=%b want 0/10/1", dut_wren, dut_done, dut_busy);
    end
    tick();
    n_cmp++; if ({dut_done, dut_busy} !== 3'b000) begin n_bad++; $display("FAIL del_idle got done=%b busy=%b want 00/0", dut_done, dut_busy); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [4];
    int acc_who [4];
    int n_acc;
    int n_viol;
    int want_who;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_desc[0] = load_d;
    req_desc[1] = load_d;
    req_valid   = 2'b11;
    #1;
    n_acc = 0;
    n_viol = 0;
    for (int c = 0; c < 120; c++) begin
      if (dut_busy && (dut_ready != 2'b00)) n_viol++;
      if (|(req_valid & dut_ready)) begin
        acc_cyc[n_acc] = c;
        acc_who[n_acc] = dut_ready[1] ? 1 : 0;
        n_acc++;
        if (n_acc == 4) begin
          tick();
          break;
        end
      end
      tick();
    end
    req_valid = 2'b00;
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL b2b_accepts got %0d want 4", n_acc); end
    for (int k = 0; k < n_acc; k++) begin
      want_who = k % 2;
      n_cmp++; if (acc_who[k] !== want_who) begin n_bad++; $display("FAIL b2b_grant%0d got %0d want %0d", k, acc_who[k], want_who); end
      if (k > 0) begin
        n_cmp++;
        if (acc_cyc[k] - acc_cyc[k-1] !== 21) begin
          n_bad++;
          $display("FAIL b2b_spacing%0d got %0d want 21", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL b2b_ready_in_burst got %0d want 0", n_viol); end
    for (int c = 0; c < 30; c++) begin
      if (!dut_busy) break;
      tick();
    end
    n_cmp++; if (dut_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got busy=%b want 0", dut_busy); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n_commit;
    int n_done;
    int n_wr;
    issue(0, load_d, 5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmb_accept got %b want 1", ok); end
    repeat (9) tick();
    n_cmp++; if ({dut_wren, dut_addr} !== {1'b1, 32'h301}) begin n_bad++; $display("FAIL rmb_write10 got wren=%b addr=%h want 1/301", dut_wren, dut_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dut_ready, dut_done, dut_busy, dut_wren, dut_addr, dut_wdata} !== 70'd0) begin
      n_bad++;
      $display("FAIL rmb_async got ready=%b done=%b busy=%b wren=%b addr=%h wdata=%h want all 0",
               dut_ready, dut_done, dut_busy, dut_wren, dut_addr, dut_wdata);
    end
    tick();
    rst_n = 1'b1;
    n_commit = 0;
    n_done = 0;
    n_wr = 0;
    for (int c = 0; c < 25; c++) begin
      if (dut_wren) n_wr++;
      if (dut_wren && (dut_addr[10:8] == 3'd0)) n_commit++;
      if (dut_done != 2'b00) n_done++;
      tick();
    end
    n_cmp++; if (n_commit !== 0) begin n_bad++; $display("FAIL rmb_commit got %0d want 0", n_commit); end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rmb_done got %0d want 0", n_done); end
    n_cmp++; if (n_wr !== 0) begin n_bad++; $display("FAIL rmb_writes got %0d want 0", n_wr); end
    req_desc[0] = del_d;
    req_desc[1] = del_d;
    req_valid = 2'b11;
    #1;
    n_cmp++; if (dut_ready !== 2'b01) begin n_bad++; $display("FAIL rmb_first_grant got %b want 01", dut_ready); end
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 25; c++) begin
      if (dut_done != 2'b00) break;
      tick();
    end
    n_cmp++; if (dut_done !== 2'b01) begin n_bad++; $display("FAIL rmb_after_done got %b want 01", dut_done); end
    tick();
  endtask

  task automatic test_drop_valid();
    bit ok;
    int n_wr;
    int n_d0;
    int n_d1;
    int n_rdy0;
    issue(1, load_d, 5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL drop_accept got %b want 1", ok); end
    n_wr = 0;
    n_d0 = 0;
    n_d1 = 0;
    n_rdy0 = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 4) begin
        req_desc[0]  = del_d;
        req_valid[0] = 1'b1;
        #1;
        n_cmp++; if (dut_ready !== 2'b00) begin n_bad++; $display("FAIL drop_ready_in_burst got %b want 00", dut_ready); end
      end
      if (c == 5) req_valid[0] = 1'b0;
      if (dut_wren) n_wr++;
      if (dut_done[0]) n_d0++;
      if (dut_done[1]) n_d1++;
      if (dut_ready[0]) n_rdy0++;
      tick();
    end
    n_cmp++; if (n_wr !== 19) begin n_bad++; $display("FAIL drop_writes got %0d want 19", n_wr); end
    n_cmp++; if (n_d1 !== 1) begin n_bad++; $display("FAIL drop_done1 got %0d want 1", n_d1); end
    n_cmp++; if (n_d0 !== 0) begin n_bad++; $display("FAIL drop_done0 got %0d want 0", n_d0); end
    n_cmp++; if (n_rdy0 !== 0) begin n_bad++; $display("FAIL drop_ready0 got %0d want 0", n_rdy0); end
  endtask

  initial begin
    req_desc = '0;
    build_descs();
    test_reset();
    test_load();
    test_delete();
    test_back_to_back();
    test_reset_mid_burst();
    test_drop_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
